// File: rtl/sdram_rd_uart_tx.sv
// sdram_rd_uart_tx: output end of the UART->SDRAM->UART path.
// Pops one 16-bit word from the read-side FIFO of the SDRAM buffer and
// sends it as two 8N1 UART frames on uart_txd. The byte order is set by
// MSB_FIRST. All outputs come straight from registers.
module sdram_rd_uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic [10:0] fifo_rusedw,
    input  logic [15:0] fifo_rdata,
    output logic        fifo_rreq,
    output logic        uart_txd,
    output logic        busy,
    output logic        word_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [15:0]      word_r;
    logic [9:0]       shift_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       bit_idx_r;
    logic             byte_sel_r;   // 0 = first byte of the word, 1 = second
    logic             rreq_r;
    logic             txd_r;
    logic             busy_r;
    logic             done_r;

    logic             start_s;
    logic             bit_end_s;
    logic             frame_end_s;

    // Byte of the word sent in slot 'second' (0 = first on the line).
    function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic second);
        logic take_hi;
        take_hi = (MSB_FIRST != 1'b0) ? ~second : second;
        return take_hi ? w[15:8] : w[7:0];
    endfunction

    // 8N1 frame: shifted out LSB first, so the start bit sits in bit 0.
    function automatic logic [9:0] build_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    assign start_s     = tx_en && (fifo_rusedw != 11'd0);
    assign bit_end_s   = (cnt_r == CNT_LAST);
    assign frame_end_s = bit_end_s && (bit_idx_r == 4'd9);

    // Next-state decode for the word fetch / byte sequencing machine.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ:   state_s = ST_LATCH;
            ST_LATCH: state_s = ST_SEND;
            ST_SEND: begin
                if (frame_end_s) begin
                    if (byte_sel_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_NEXT;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_NEXT:  state_s = ST_SEND;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: FIFO read pulse, word capture, frame shifting, bit timing, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r     <= 16'h0000;
            shift_r    <= 10'd0;
            cnt_r      <= CNT_ZERO;
            bit_idx_r  <= 4'd0;
            byte_sel_r <= 1'b0;
            rreq_r     <= 1'b0;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rreq_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // rreq and busy rise together so busy covers the REQ cycle.
                    if (start_s) begin
                        rreq_r <= 1'b1;
                        busy_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // FIFO q becomes valid on the next cycle; nothing to do yet.
                end
                ST_LATCH: begin
                    word_r     <= fifo_rdata;
                    shift_r    <= build_frame(pick_byte(fifo_rdata, 1'b0));
                    cnt_r      <= CNT_ZERO;
                    bit_idx_r  <= 4'd0;
                    byte_sel_r <= 1'b0;
                    txd_r      <= 1'b0;
                end
                ST_SEND: begin
                    // Registered word_done lands in the last stop-bit cycle.
                    done_r <= byte_sel_r && (bit_idx_r == 4'd9) && (cnt_r == CNT_PRE);
                    if (bit_end_s) begin
                        cnt_r <= CNT_ZERO;
                        if (bit_idx_r == 4'd9) begin
                            if (byte_sel_r) begin
                                busy_r <= 1'b0;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                            shift_r   <= {1'b1, shift_r[9:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_NEXT: begin
                    // Line stays at stop level during this cycle.
                    shift_r    <= build_frame(pick_byte(word_r, 1'b1));
                    cnt_r      <= CNT_ZERO;
                    bit_idx_r  <= 4'd0;
                    byte_sel_r <= 1'b1;
                    txd_r      <= 1'b0;
                end
                default: begin
                    txd_r  <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rreq = rreq_r;
    assign uart_txd  = txd_r;
    assign busy      = busy_r;
    assign word_done = done_r;

endmodule

// File: tb/tb_sdram_rd_uart_tx.sv
// Bench for sdram_rd_uart_tx: two instances (MSB-first and LSB-first), each
// fed by a small FIFO model. A per-cycle reference derives the expected
// line level, rreq, busy and word_done from the word start time and the
// word value using the frame timing arithmetic.
module tb_sdram_rd_uart_tx;

    localparam int D      = 10;          // 50 MHz / 5 MBd
    localparam int WORD_T = 4 + 20 * D;  // decision cycle to next possible decision

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_en = 1'b0;
    logic [10:0] rusedw [2] = '{11'd0, 11'd0};
    logic [15:0] rdata  [2] = '{16'h0000, 16'h0000};
    logic        rreq   [2];
    logic        txd    [2];
    logic        busy   [2];
    logic        done   [2];

    logic [15:0] mem    [2][256];
    int          wr_ptr [2] = '{0, 0};
    int          rd_ptr [2] = '{0, 0};
    int          t0     [2] = '{-1, -1};
    logic [15:0] mword  [2] = '{16'h0000, 16'h0000};
    int          n_rreq [2] = '{0, 0};
    int          n_done [2] = '{0, 0};
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        sdram_rd_uart_tx #(
            .CLK_FREQ (50_000_000),
            .BAUD     (5_000_000),
            .MSB_FIRST(gi == 0)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .tx_en      (tx_en),
            .fifo_rusedw(rusedw[gi]),
            .fifo_rdata (rdata[gi]),
            .fifo_rreq  (rreq[gi]),
            .uart_txd   (txd[gi]),
            .busy       (busy[gi]),
            .word_done  (done[gi])
        );
    end

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Level of frame bit k: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k == 9) return 1'b1;
        else return b[k-1];
    endfunction

    // Expected {rreq, busy, word_done, txd} at offset o from the decision cycle.
    function automatic logic [3:0] expect_at(input int o, input logic [15:0] w, input bit msb);
        logic [7:0] b0;
        logic [7:0] b1;
        logic       t;
        b0 = msb ? w[15:8] : w[7:0];
        b1 = msb ? w[7:0]  : w[15:8];
        if (o >= 3 && o < 3 + 10 * D) t = frame_bit(b0, (o - 3) / D);
        else if (o >= 4 + 10 * D && o < 4 + 20 * D) t = frame_bit(b1, (o - 4 - 10 * D) / D);
        else t = 1'b1;
        return {o == 1, (o >= 1 && o <= 3 + 20 * D), o == 3 + 20 * D, t};
    endfunction

    task automatic push(input int i, input logic [15:0] w);
        mem[i][wr_ptr[i] % 256] = w;
        wr_ptr[i] = wr_ptr[i] + 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // FIFO model plus per-cycle reference check, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [3:0] e;
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rreq[i] === 1'b1) begin
                n_rreq[i] = n_rreq[i] + 1;
                if (wr_ptr[i] != rd_ptr[i]) begin
                    rdata[i]  = mem[i][rd_ptr[i] % 256];
                    rd_ptr[i] = rd_ptr[i] + 1;
                end
            end
            if (done[i] === 1'b1) n_done[i] = n_done[i] + 1;
            rusedw[i] = 11'(wr_ptr[i] - rd_ptr[i]);

            if (!rst_n) begin
                t0[i] = -1;
                e = 4'b0001;
            end else begin
                if (t0[i] >= 0 && (cyc - t0[i]) >= WORD_T) t0[i] = -1;
                if (t0[i] < 0) e = 4'b0001;
                else e = expect_at(cyc - t0[i], mword[i], i == 0);
            end
            check_eq($sformatf("rreq%0d", i), 32'(rreq[i]), 32'(e[3]));
            check_eq($sformatf("busy%0d", i), 32'(busy[i]), 32'(e[2]));
            check_eq($sformatf("word_done%0d", i), 32'(done[i]), 32'(e[1]));
            check_eq($sformatf("uart_txd%0d", i), 32'(txd[i]), 32'(e[0]));

            if (rst_n && t0[i] < 0 && tx_en && rusedw[i] != 11'd0) begin
                t0[i]    = cyc;
                mword[i] = mem[i][rd_ptr[i] % 256];
            end
        end
    end

    initial begin
        int base0;
        int base1;
        int dbase0;
        rst_n = 1'b0;
        tx_en = 1'b0;
        step(5);
        rst_n = 1'b1;
        step(3);

        // Single word on each instance: 0xA55A MSB-first, 0x1234 LSB-first.
        base0 = n_rreq[0]; base1 = n_rreq[1]; dbase0 = n_done[0];
        push(0, 16'hA55A);
        push(1, 16'h1234);
        tx_en = 1'b1;
        step(WORD_T + 10);
        check_eq("single_rreq0", 32'(n_rreq[0] - base0), 32'd1);
        check_eq("single_rreq1", 32'(n_rreq[1] - base1), 32'd1);
        check_eq("single_done0", 32'(n_done[0] - dbase0), 32'd1);

        // Back-to-back words.
        base0 = n_rreq[0]; base1 = n_rreq[1];
        push(0, 16'h0001); push(0, 16'h0002); push(0, 16'h0003);
        for (int k = 0; k < 3; k++) push(1, 16'($urandom));
        step(3 * WORD_T + 10);
        check_eq("b2b_rreq0", 32'(n_rreq[0] - base0), 32'd3);
        check_eq("b2b_rreq1", 32'(n_rreq[1] - base1), 32'd3);

        // Empty FIFO for 1000 cycles, then a single word arrives.
        base0 = n_rreq[0];
        step(1000);
        check_eq("empty_rreq0", 32'(n_rreq[0] - base0), 32'd0);
        push(0, 16'($urandom));
        step(WORD_T + 10);
        check_eq("refill_rreq0", 32'(n_rreq[0] - base0), 32'd1);

        // tx_en dropped mid byte 0 with five words waiting.
        base0 = n_rreq[0];
        for (int k = 0; k < 5; k++) push(0, 16'($urandom));
        step(50);
        tx_en = 1'b0;
        step(600);
        check_eq("gate_rreq0", 32'(n_rreq[0] - base0), 32'd1);
        tx_en = 1'b1;
        step(4 * WORD_T + 10);
        check_eq("ungate_rreq0", 32'(n_rreq[0] - base0), 32'd5);

        // Reset during byte-1 data bits, then a fresh word from the remaining entry.
        base0 = n_rreq[0];
        push(0, 16'($urandom)); push(0, 16'($urandom));
        push(1, 16'($urandom));
        step(150);
        rst_n = 1'b0;
        #1;
        check_eq("rst_txd0", 32'(txd[0]), 32'd1);
        check_eq("rst_busy0", 32'(busy[0]), 32'd0);
        check_eq("rst_rreq0", 32'(rreq[0]), 32'd0);
        check_eq("rst_txd1", 32'(txd[1]), 32'd1);
        step(3);
        rst_n = 1'b1;
        step(WORD_T + 10);
        check_eq("rst_rreq_total0", 32'(n_rreq[0] - base0), 32'd2);

        // Random phase: random words, random tx_en, random durations.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) push(int'($urandom_range(0, 1)), 16'($urandom));
            tx_en = 1'($urandom_range(0, 1));
            step(int'($urandom_range(100, 600)));
        end
        tx_en = 1'b1;
        step(20 * WORD_T);
        check_eq("drain0", 32'(rusedw[0]), 32'd0);
        check_eq("drain1", 32'(rusedw[1]), 32'd0);
        check_eq("idle_busy0", 32'(busy[0]), 32'd0);
        check_eq("idle_txd1", 32'(txd[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
